// File: rtl/des_region_scheduler_if.sv
// Bus bundle between the region scheduler, the CPU register block and the DES wrapper array.
// The scheduler sits on the master modport; the CPU side and the workers sit on the slave modport.
interface des_region_scheduler_if #(
  parameter int NUM_WORKERS = 4,
  parameter int CNT_W       = 64
);
  logic                         start;
  logic                         abort;
  logic [31:0]                  first_region;
  logic [31:0]                  last_region;
  logic [31:0]                  w_cmd;
  logic [31:0]                  w_region;
  logic [NUM_WORKERS-1:0]       w_cmd_valid;
  logic [NUM_WORKERS-1:0]       w_cmd_read;
  logic [NUM_WORKERS-1:0]       w_done;
  logic [NUM_WORKERS*CNT_W-1:0] w_counter;
  logic                         res_valid;
  logic                         res_ready;
  logic [31:0]                  res_region;
  logic [CNT_W-1:0]             res_counter;
  logic [CNT_W-1:0]             total;
  logic                         busy;
  logic                         job_done;

  modport master (
    input  start, abort, first_region, last_region, w_cmd_read, w_done, w_counter, res_ready,
    output w_cmd, w_region, w_cmd_valid, res_valid, res_region, res_counter, total, busy, job_done
  );

  modport slave (
    output start, abort, first_region, last_region, w_cmd_read, w_done, w_counter, res_ready,
    input  w_cmd, w_region, w_cmd_valid, res_valid, res_region, res_counter, total, busy, job_done
  );
endinterface

// File: rtl/des_region_scheduler.sv
// Hands regions first..last to a pool of DES wrappers one command at a time, collects each
// worker's final counter round-robin and streams the per-region results to the CPU.
module des_region_scheduler #(
  parameter int          NUM_WORKERS     = 4,
  parameter int          CNT_W           = 64,
  parameter logic [31:0] CMD_READ_REGION = 32'd1,
  parameter logic [31:0] CMD_START       = 32'd2,
  parameter logic [31:0] CMD_RESTART     = 32'd3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  des_region_scheduler_if.master bus
);
  localparam int IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NUM_WORKERS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_CMD     = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RESULT  = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [NUM_WORKERS-1:0] active_q, active_d;
  logic [31:0]            tag_q [NUM_WORKERS];
  logic [31:0]            tag_d [NUM_WORKERS];
  logic [32:0]            next_region_q, next_region_d;
  logic [31:0]            last_region_q, last_region_d;
  logic [IDX_W-1:0]       rr_q, rr_d, sel_q, sel_d;
  logic                   abort_q, abort_d;
  logic [31:0]            w_cmd_q, w_cmd_d, w_region_q, w_region_d;
  logic [NUM_WORKERS-1:0] w_cmd_valid_q, w_cmd_valid_d;
  logic                   res_valid_q, res_valid_d;
  logic [31:0]            res_region_q, res_region_d;
  logic [CNT_W-1:0]       res_counter_q, res_counter_d, total_q, total_d;
  logic                   busy_q, job_done_q;

  logic [CNT_W-1:0]       counter_w [NUM_WORKERS];
  logic [NUM_WORKERS-1:0] cand;
  logic                   found_done, found_active, found_idle;
  logic [IDX_W-1:0]       done_idx, active_idx, idle_idx;
  logic [IDX_W:0]         pos, rr_inc;

  for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_cnt
    assign counter_w[gi] = bus.w_counter[gi*CNT_W +: CNT_W];
  end

  assign cand = active_q & bus.w_done;

  // Descending scans so the lowest index (or the one closest to rr) overwrites last and wins.
  always_comb begin
    found_done   = 1'b0;
    found_active = 1'b0;
    found_idle   = 1'b0;
    done_idx     = '0;
    active_idx   = '0;
    idle_idx     = '0;
    pos          = '0;
    for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
      if (active_q[k]) begin
        found_active = 1'b1;
        active_idx   = IDX_W'(k);
      end else begin
        found_idle = 1'b1;
        idle_idx   = IDX_W'(k);
      end
      pos = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (cand[pos[IDX_W-1:0]]) begin
        found_done = 1'b1;
        done_idx   = pos[IDX_W-1:0];
      end
    end
    rr_inc = {1'b0, done_idx} + (IDX_W + 1)'(1);
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    tag_d         = tag_q;
    next_region_d = next_region_q;
    last_region_d = last_region_q;
    rr_d          = rr_q;
    sel_d         = sel_q;
    abort_d       = abort_q;
    w_cmd_d       = w_cmd_q;
    w_region_d    = w_region_q;
    w_cmd_valid_d = w_cmd_valid_q;
    res_valid_d   = res_valid_q;
    res_region_d  = res_region_q;
    res_counter_d = res_counter_q;
    total_d       = total_q;
    if (state_q != S_IDLE && bus.abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          next_region_d = {1'b0, bus.first_region};
          last_region_d = bus.last_region;
          total_d       = '0;
          rr_d          = '0;
          abort_d       = 1'b0;
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort_q && found_active) begin
          w_cmd_d       = CMD_RESTART;
          w_region_d    = tag_q[active_idx];
          sel_d         = active_idx;
          w_cmd_valid_d = NUM_WORKERS'(1) << active_idx;
          state_d       = S_CMD;
        end else if (abort_q) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (found_done) begin
          res_counter_d = counter_w[done_idx];
          res_region_d  = tag_q[done_idx];
          rr_d          = (rr_inc == N_W) ? '0 : rr_inc[IDX_W-1:0];
          sel_d         = done_idx;
          res_valid_d   = 1'b1;
          state_d       = S_RESULT;
        end else if (next_region_q <= {1'b0, last_region_q} && found_idle) begin
          w_cmd_d       = CMD_READ_REGION;
          w_region_d    = next_region_q[31:0];
          sel_d         = idle_idx;
          w_cmd_valid_d = NUM_WORKERS'(1) << idle_idx;
          state_d       = S_CMD;
        end else if (!found_active && next_region_q > {1'b0, last_region_q}) begin
          state_d = S_FINISH;
        end
      end
      S_CMD: begin
        if (bus.w_cmd_read[sel_q]) begin
          w_cmd_valid_d = '0;
          state_d       = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // The command word itself tells us where we are in the per-worker sequence.
        if (!bus.w_cmd_read[sel_q]) begin
          if (w_cmd_q == CMD_READ_REGION) begin
            w_cmd_d       = CMD_START;
            w_cmd_valid_d = NUM_WORKERS'(1) << sel_q;
            state_d       = S_CMD;
          end else if (w_cmd_q == CMD_START) begin
            active_d[sel_q] = 1'b1;
            tag_d[sel_q]    = w_region_q;
            next_region_d   = next_region_q + 33'd1;
            state_d         = S_SCAN;
          end else begin
            active_d[sel_q] = 1'b0;
            state_d         = S_SCAN;
          end
        end
      end
      S_RESULT: begin
        if (abort_q || bus.abort || bus.res_ready) begin
          if (!(abort_q || bus.abort)) total_d = total_q + res_counter_q;
          res_valid_d   = 1'b0;
          w_cmd_d       = CMD_RESTART;
          w_region_d    = res_region_q;
          w_cmd_valid_d = NUM_WORKERS'(1) << sel_q;
          state_d       = S_CMD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      active_q      <= '0;
      for (int i = 0; i < NUM_WORKERS; i++) tag_q[i] <= '0;
      next_region_q <= '0;
      last_region_q <= '0;
      rr_q          <= '0;
      sel_q         <= '0;
      abort_q       <= 1'b0;
      w_cmd_q       <= '0;
      w_region_q    <= '0;
      w_cmd_valid_q <= '0;
      res_valid_q   <= 1'b0;
      res_region_q  <= '0;
      res_counter_q <= '0;
      total_q       <= '0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      tag_q         <= tag_d;
      next_region_q <= next_region_d;
      last_region_q <= last_region_d;
      rr_q          <= rr_d;
      sel_q         <= sel_d;
      abort_q       <= abort_d;
      w_cmd_q       <= w_cmd_d;
      w_region_q    <= w_region_d;
      w_cmd_valid_q <= w_cmd_valid_d;
      res_valid_q   <= res_valid_d;
      res_region_q  <= res_region_d;
      res_counter_q <= res_counter_d;
      total_q       <= total_d;
      busy_q        <= (state_d != S_IDLE);
      job_done_q    <= (state_d == S_FINISH);
    end
  end

  assign bus.w_cmd       = w_cmd_q;
  assign bus.w_region    = w_region_q;
  assign bus.w_cmd_valid = w_cmd_valid_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_region  = res_region_q;
  assign bus.res_counter = res_counter_q;
  assign bus.total       = total_q;
  assign bus.busy        = busy_q;
  assign bus.job_done    = job_done_q;
endmodule

// File: tb/tb_des_region_scheduler.sv
// Directed bench for des_region_scheduler with two modelled DES wrappers and a result
// scoreboard that checks the CPU-side stream every cycle.
module tb_des_region_scheduler;
  localparam int NW = 2;
  localparam logic [31:0] CMD_READ    = 32'd1;
  localparam logic [31:0] CMD_START   = 32'd2;
  localparam logic [31:0] CMD_RESTART = 32'd3;
  localparam int DONE_LAT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_region_scheduler_if #(.NUM_WORKERS(NW), .CNT_W(64)) bus ();

  des_region_scheduler #(
    .NUM_WORKERS(NW), .CNT_W(64),
    .CMD_READ_REGION(CMD_READ), .CMD_START(CMD_START), .CMD_RESTART(CMD_RESTART)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- worker models ----------------
  logic [NW-1:0] ack, running, done_auto;
  logic [NW-1:0] force_done = '0;
  logic          auto_done = 1'b1;
  int            ack_lat [NW] = '{1, 4};
  int            lat_cnt [NW];
  int            timer [NW];
  logic [31:0]   rd_region [NW];
  int            cnt_read [16];
  int            cnt_start [16];
  int            cnt_restart [16];
  int            wr_restart [NW];

  assign bus.w_cmd_read = ack;
  assign bus.w_done     = done_auto | (force_done & running);
  always_comb begin
    bus.w_counter = '0;
    for (int i = 0; i < NW; i++) bus.w_counter[i*64 +: 64] = 64'(rd_region[i]) * 64'd3 + 64'd1;
  end

  initial begin
    for (int r = 0; r < 16; r++) begin cnt_read[r] = 0; cnt_start[r] = 0; cnt_restart[r] = 0; end
    for (int i = 0; i < NW; i++) wr_restart[i] = 0;
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= '0; running <= '0; done_auto <= '0;
      for (int i = 0; i < NW; i++) begin lat_cnt[i] <= 0; timer[i] <= 0; rd_region[i] <= '0; end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (running[i] && timer[i] > 0) begin
          timer[i] <= timer[i] - 1;
          if (timer[i] == 1 && auto_done) done_auto[i] <= 1'b1;
        end
        if (bus.w_cmd_valid[i] != ack[i]) begin
          if (lat_cnt[i] + 1 >= ack_lat[i]) begin
            lat_cnt[i] <= 0;
            ack[i]     <= bus.w_cmd_valid[i];
            if (bus.w_cmd_valid[i]) begin
              case (bus.w_cmd)
                CMD_READ: begin
                  rd_region[i] <= bus.w_region;
                  if (bus.w_region < 16) cnt_read[bus.w_region[3:0]] <= cnt_read[bus.w_region[3:0]] + 1;
                end
                CMD_START: begin
                  check("start_region", 64'(bus.w_region), 64'(rd_region[i]));
                  running[i] <= 1'b1; timer[i] <= DONE_LAT; done_auto[i] <= 1'b0;
                  if (bus.w_region < 16) cnt_start[bus.w_region[3:0]] <= cnt_start[bus.w_region[3:0]] + 1;
                end
                CMD_RESTART: begin
                  running[i] <= 1'b0; timer[i] <= 0; done_auto[i] <= 1'b0;
                  wr_restart[i] <= wr_restart[i] + 1;
                  if (bus.w_region < 16) cnt_restart[bus.w_region[3:0]] <= cnt_restart[bus.w_region[3:0]] + 1;
                end
                default: check("cmd_code", 64'(bus.w_cmd), 64'(CMD_READ));
              endcase
            end
          end else begin
            lat_cnt[i] <= lat_cnt[i] + 1;
          end
        end else begin
          lat_cnt[i] <= 0;
        end
      end
    end
  end

  // ---------------- result scoreboard, checked every cycle ----------------
  logic [63:0] model_total = '0;
  logic        prev_hold = 1'b0, prev_drop = 1'b0;
  logic [31:0] prev_region;
  logic [63:0] prev_counter;
  int          res_log [$];
  int          job_done_cnt = 0, cmd_valid_cycles = 0, res_valid_cycles = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_total = '0; prev_hold = 1'b0; prev_drop = 1'b0;
    end else begin
      check("cmd_valid_onehot", 64'(bus.w_cmd_valid & (bus.w_cmd_valid - 1'b1)), 64'd0);
      check("total", bus.total, model_total);
      if (prev_hold) begin
        check("hold_res_valid", 64'(bus.res_valid), 64'd1);
        check("hold_res_region", 64'(bus.res_region), 64'(prev_region));
        check("hold_res_counter", bus.res_counter, prev_counter);
      end
      if (prev_drop) check("abort_drop_res_valid", 64'(bus.res_valid), 64'd0);
      if (bus.res_valid) begin
        res_valid_cycles++;
        check("res_counter_vs_region", bus.res_counter, 64'(bus.res_region) * 64'd3 + 64'd1);
        if (bus.res_ready && !bus.abort) begin
          model_total = model_total + bus.res_counter;
          res_log.push_back(int'(bus.res_region));
        end
      end
      if (bus.start && !bus.busy) model_total = '0;
      if (bus.job_done) job_done_cnt++;
      if (bus.w_cmd_valid != '0) cmd_valid_cycles++;
      prev_hold    = bus.res_valid && !bus.res_ready && !bus.abort;
      prev_drop    = bus.res_valid && bus.abort;
      prev_region  = bus.res_region;
      prev_counter = bus.res_counter;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0: return bus.job_done;
      1: return bus.res_valid;
      2: return !bus.busy;
      3: return running == 2'b11;
      4: return running[0] && rd_region[0] == 32'd2;
      5: return bus.w_cmd_valid == 2'b10;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_until(input string name, input int what, input int bound);
    int n = 0;
    while (!cond(what) && n < bound) begin tick(); n++; end
    check(name, 64'(cond(what)), 64'd1);
  endtask

  task automatic start_job(input logic [31:0] first, input logic [31:0] last);
    bus.first_region = first;
    bus.last_region  = last;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_w_cmd_valid"}, 64'(bus.w_cmd_valid), 64'd0);
    check({tag, "_w_cmd"}, 64'(bus.w_cmd), 64'd0);
    check({tag, "_w_region"}, 64'(bus.w_region), 64'd0);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_res_region"}, 64'(bus.res_region), 64'd0);
    check({tag, "_res_counter"}, bus.res_counter, 64'd0);
    check({tag, "_total"}, bus.total, 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_job_done"}, 64'(bus.job_done), 64'd0);
  endtask

  initial begin
    int base, jd0, cv0, rv0, rs0, rs1, mask;
    logic [31:0] snap_region;
    logic [63:0] snap_counter;
    bus.start = 1'b0; bus.abort = 1'b0; bus.res_ready = 1'b1;
    bus.first_region = '0; bus.last_region = '0;

    // Reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    check_outputs_zero("post_reset");

    // Range 0..3 with timed workers
    base = res_log.size();
    jd0  = job_done_cnt;
    start_job(32'd0, 32'd3);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    tick();
    check("first_cmd_valid", 64'(bus.w_cmd_valid), 64'd1);
    check("first_cmd", 64'(bus.w_cmd), 64'(CMD_READ));
    check("first_region", 64'(bus.w_region), 64'd0);
    wait_until("range_job_done", 0, 1000);
    tick();
    check("range_busy_fall", 64'(bus.busy), 64'd0);
    check("range_total", bus.total, 64'd22);
    check("range_job_done_count", 64'(job_done_cnt - jd0), 64'd1);
    check("range_result_count", 64'(res_log.size() - base), 64'd4);
    mask = 0;
    for (int k = base; k < res_log.size(); k++) mask |= (1 << res_log[k]);
    check("range_regions_once", 64'(mask), 64'hF);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("read_cnt_r%0d", r), 64'(cnt_read[r]), 64'd1);
      check($sformatf("start_cnt_r%0d", r), 64'(cnt_start[r]), 64'd1);
      check($sformatf("restart_cnt_r%0d", r), 64'(cnt_restart[r]), 64'd1);
    end

    // Empty range: FINISH two cycles after start, no commands
    cv0 = cmd_valid_cycles;
    start_job(32'd5, 32'd4);
    check("empty_job_done_early", 64'(bus.job_done), 64'd0);
    check("empty_busy", 64'(bus.busy), 64'd1);
    tick();
    check("empty_job_done", 64'(bus.job_done), 64'd1);
    tick();
    check("empty_job_done_pulse", 64'(bus.job_done), 64'd0);
    check("empty_busy_fall", 64'(bus.busy), 64'd0);
    check("empty_total", bus.total, 64'd0);
    check("empty_no_cmd", 64'(cmd_valid_cycles - cv0), 64'd0);

    // Simultaneous done with rr pointing at worker 1
    auto_done = 1'b0;
    start_job(32'd0, 32'd2);
    wait_until("simul_both_running", 3, 300);
    force_done = 2'b01;
    wait_until("simul_first_result", 1, 300);
    check("simul_res0_region", 64'(bus.res_region), 64'd0);
    force_done = 2'b00;
    wait_until("simul_w0_region2", 4, 300);
    force_done = 2'b11;
    wait_until("simul_second_result", 1, 300);
    check("simul_res1_region", 64'(bus.res_region), 64'd1);
    check("simul_res1_counter", bus.res_counter, 64'd4);
    tick();
    wait_until("simul_third_result", 1, 300);
    check("simul_res2_region", 64'(bus.res_region), 64'd2);
    check("simul_res2_counter", bus.res_counter, 64'd7);
    wait_until("simul_job_done", 0, 300);
    force_done = 2'b00;
    tick();
    check("simul_total", bus.total, 64'd12);

    // Result backpressure
    auto_done = 1'b1;
    bus.res_ready = 1'b0;
    start_job(32'd0, 32'd1);
    wait_until("bp_res_valid", 1, 300);
    check("bp_res_region", 64'(bus.res_region), 64'd0);
    check("bp_res_counter", bus.res_counter, 64'd1);
    snap_region  = bus.res_region;
    snap_counter = bus.res_counter;
    for (int c = 0; c < 50; c++) begin
      tick();
      check("bp_no_cmd_valid", 64'(bus.w_cmd_valid), 64'd0);
    end
    check("bp_region_stable", 64'(bus.res_region), 64'(snap_region));
    check("bp_counter_stable", bus.res_counter, snap_counter);
    check("bp_total_held", bus.total, 64'd0);
    bus.res_ready = 1'b1;
    wait_until("bp_job_done", 0, 300);
    tick();
    check("bp_total", bus.total, 64'd5);

    // Abort with both workers active
    auto_done = 1'b0;
    start_job(32'd0, 32'd9);
    wait_until("abort_both_running", 3, 300);
    rs0 = wr_restart[0]; rs1 = wr_restart[1];
    jd0 = job_done_cnt;  rv0 = res_valid_cycles;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_until("abort_busy_fall", 2, 300);
    tick();
    check("abort_restart_w0", 64'(wr_restart[0] - rs0), 64'd1);
    check("abort_restart_w1", 64'(wr_restart[1] - rs1), 64'd1);
    check("abort_no_job_done", 64'(job_done_cnt - jd0), 64'd0);
    check("abort_no_res_valid", 64'(res_valid_cycles - rv0), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);

    // Reset in the middle of a handshake to worker 1
    auto_done = 1'b1;
    start_job(32'd0, 32'd3);
    wait_until("mid_cmd_valid_w1", 5, 300);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    base = res_log.size();
    start_job(32'd7, 32'd8);
    wait_until("restart_job_done", 0, 500);
    tick();
    check("restart_total", bus.total, 64'd47);
    check("restart_result_count", 64'(res_log.size() - base), 64'd2);
    if (res_log.size() - base == 2) begin
      check("restart_first_region", 64'(res_log[base]), 64'd7);
      check("restart_second_region", 64'(res_log[base + 1]), 64'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/des_region_scheduler.md
# des_region_scheduler

Job-level controller that shares one region range across `NUM_WORKERS` DES block wrappers. It serialises the wrapper command protocol (`CMD_READ_REGION`, `CMD_START`, `CMD_RESTART`) over one shared command/region bus with per-worker valid lines. It collects each worker's final counter and streams per-region results to the CPU interface with a valid/ready handshake. It sits between the CPU register interface and the array of DES wrappers.

## Interface
- `NUM_WORKERS`, 4: number of attached DES wrappers (1..16).
- `CNT_W`, 64: width of the worker counter, the result counter and the accumulator.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset. One clock; no other reset exists.
- `start` in 1: single-cycle pulse; begins a job. Accepted only in IDLE.
- `abort` in 1: single-cycle pulse; cancels the running job.
- `first_region`, `last_region` in 32 each: inclusive region range, sampled on an accepted `start`.
- `w_cmd` out 32: shared command to the workers.
- `w_region` out 32: shared region operand to the workers.
- `w_cmd_valid` out NUM_WORKERS: per-worker command valid, one-hot or zero.
- `w_cmd_read` in NUM_WORKERS: per-worker command-read acknowledge.
- `w_done` in NUM_WORKERS: per-worker search done (level).
- `w_counter` in NUM_WORKERS*CNT_W: worker i occupies bits [i*CNT_W +: CNT_W].
- `res_valid` out 1: result available.
- `res_ready` in 1: CPU accepts the result.
- `res_region` out 32: region that produced the result.
- `res_counter` out CNT_W: that region's final counter.
- `total` out CNT_W: running sum of accepted `res_counter` values, wrapping mod 2^CNT_W. Cleared on an accepted `start`.
- `busy` out 1: high outside IDLE.
- `job_done` out 1: one-cycle pulse when every region has been reported.

## Operation
- Per-worker state: `active` bit and a 32-bit region tag. Job state: `next_region`, 33 bits, so the counter does not wrap at 0xFFFFFFFF. Also a round-robin pointer `rr`.
- States: IDLE, SCAN, CMD, RELEASE, RESULT, FINISH.
- **IDLE.** On `start`:
  - load `next_region` = `first_region`, clear `total`, clear `rr`;
  - go to SCAN.
- **SCAN.** Evaluated in this priority order:
  1. Abort pending and any worker active: issue `CMD_RESTART` to the lowest-index active worker, discarding its result.
  2. Abort pending and no worker active: clear the abort flag and go to IDLE. `job_done` is not pulsed.
  3. Any worker with `active` and `w_done` set, searched round-robin from `rr`: capture its `w_counter` into `res_counter` and its tag into `res_region`. Set `rr` to that index + 1 mod N. Go to RESULT.
  4. `next_region` ≤ `last_region` and any inactive worker, taking the lowest index: run the `CMD_READ_REGION` sequence with `w_region` = `next_region`, then `CMD_START`. Then set the worker's `active` bit, set its tag to `next_region`, and increment `next_region`.
  5. No worker active and `next_region` > `last_region`: go to FINISH.
  6. Otherwise stay in SCAN.
- **CMD/RELEASE handshake**, one command at a time:
  - CMD: drive `w_cmd`, `w_region` and the selected `w_cmd_valid` bit; hold them until `w_cmd_read` of that worker is 1.
  - RELEASE: drop `w_cmd_valid` and keep `w_cmd` and `w_region` stable until that `w_cmd_read` returns to 0.
  - Then continue the sequence, or return to SCAN.
- **RESULT.** Hold `res_valid` until `res_ready`. In the accept cycle, add `res_counter` to `total`. Then issue `CMD_RESTART` to that worker and clear its `active` bit.
- **FINISH.** Pulse `job_done` for one cycle, then go to IDLE.
- **Abort.** `abort` in a non-IDLE state sets the abort flag. The flag acts only at SCAN, so an in-flight handshake always completes. An abort in RESULT drops `res_valid` immediately without updating `total`, then issues `CMD_RESTART`. `abort` in IDLE is ignored.
- `start` outside IDLE is ignored.
- If `last_region` < `first_region`, no command is issued, the block goes straight to FINISH, and `total` = 0.

## Timing
- Reset values: all outputs 0 (`w_cmd_valid`, `w_cmd`, `w_region`, `res_*`, `total`, `busy`, `job_done`). All internal state is cleared. Reset in the middle of a handshake drops `w_cmd_valid` asynchronously.
- All outputs are registered.
- `busy` rises the cycle after `start` is accepted.
- The first `w_cmd_valid` rises 2 cycles after `start`: IDLE→SCAN, then SCAN→CMD.
- Each command takes at least 2 cycles plus the worker's acknowledge latency in each direction. The worker synchronises `w_cmd_valid` through registers, so acknowledge latency is unbounded; no timeout.
- `res_valid` rises 1 cycle after SCAN selects a done worker.
- `total` updates on the clock edge ending the accept cycle.
- A `w_done` and an idle-worker opportunity in the same SCAN cycle: collection wins.

## Test plan
- Range and counters: NUM_WORKERS=2, first=0, last=3, worker model done 10 cycles after start with counter = 3·region+1 -> four results, each region exactly once, `total`=22, one `job_done`, each worker received READ_REGION/START/RESTART per region.
- Empty range: first=5, last=4 -> `job_done` 2 cycles after `start`, `w_cmd_valid` never asserted, `total`=0.
- Simultaneous done: workers 0 and 1 raise `w_done` in the same cycle with `rr`=1 -> worker 1's result is presented first, then worker 0's.
- Result backpressure: `res_ready` held low for 50 cycles -> `res_valid` and `res_counter` stable, no new `w_cmd_valid`, `total` unchanged until accept.
- Abort: `abort` with 2 workers active -> each receives `CMD_RESTART`, no further `res_valid`, `busy` falls, no `job_done`.
- Reset mid-handshake: `rst_n` low while `w_cmd_valid`=0010 -> all outputs 0 immediately without a clock edge; after release, a new `start` restarts correctly.
